apb_master_exe_seq: RTL and testbench
=====================================

Name: apb_master_exe_seq

Overview:
- APB requester that drives the APB-wrapped execution-unit slave from the other end of the bus.
- Accepts one command (operation code plus two operands) from a local controller.
- Runs the fixed APB sequence: write oper → write argA → write argB → wait for the exe unit → read result → read status.
- Returns result, status and an error flag to the controller with a done pulse; sits between a test/sequencer controller and the slave's APB port.

Parameters:
- DATA_WIDTH, 8, APB data width and operand/result width; must be ≥4 because status is 4 bits.
- ADDR_WIDTH, 16, APB address width.
- EXE_LAT, 2, idle cycles inserted between the last write and the first read (range 0..255).
- TIMEOUT, 15, maximum ACCESS-phase cycles without i_PREADY before the command is aborted (range 1..255).

Ports:
- i_PCLK  in  1  clock, rising edge.
- i_PRESET  in  1  reset, asynchronous, active-high.
- i_start  in  1  command request; sampled only when idle.
- i_oper  in  DATA_WIDTH  operation code.
- i_argA  in  DATA_WIDTH  operand A.
- i_argB  in  DATA_WIDTH  operand B.
- o_busy  out  1  high from the accepting edge until o_done.
- o_done  out  1  one-cycle pulse marking command completion.
- o_result  out  DATA_WIDTH  result read from address 0.
- o_status  out  4  status read from address 1 (i_PRDATA[3:0]).
- o_err  out  1  PSLVERR or timeout in the last command; valid with o_done.
- o_PADDR  out  ADDR_WIDTH  APB address.
- o_PSEL  out  1  APB select.
- o_PENABLE  out  1  APB enable.
- o_PWRITE  out  1  APB direction (1 = write).
- o_PWDATA  out  DATA_WIDTH  APB write data.
- i_PREADY  in  1  APB ready.
- i_PRDATA  in  DATA_WIDTH  APB read data.
- i_PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (i_PRESET high, asynchronous): all outputs 0, FSM=IDLE, counters 0. Reset mid-transfer drops PSEL/PENABLE immediately with no completion pulse.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, WAIT_EXE.
- Transfer index k=0..4:
  - k=0: write addr 0, data oper.
  - k=1: write addr 1, data argA.
  - k=2: write addr 2, data argB.
  - k=3: read addr 0.
  - k=4: read addr 1.
- IDLE: on i_start=1, latch oper/argA/argB, set k=0, o_busy=1, clear o_err, go to SETUP. i_start while busy is ignored; operand changes after acceptance have no effect.
- SETUP (one cycle): PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA are driven for k (PWDATA=0 on reads). Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with address/data/direction held stable. The timeout counter increments each cycle without PREADY.
  - i_PREADY=1 and i_PSLVERR=0: transfer completes.
    - On k=3, capture o_result=i_PRDATA; on k=4, capture o_status=i_PRDATA[3:0].
    - Drop PSEL/PENABLE the next cycle.
    - After k=2 go to WAIT_EXE (or straight to SETUP if EXE_LAT=0); after k=4 go to IDLE; otherwise k+1 and SETUP.
  - i_PREADY=1 and i_PSLVERR=1: abort. o_err=1, o_result=0, o_status=0, go to IDLE.
  - Counter reaches TIMEOUT with no PREADY: same abort; PSEL/PENABLE drop the next cycle.
- WAIT_EXE: PSEL=0 for EXE_LAT cycles, then k=3 and SETUP.
- Completion: on entering IDLE from a finished or aborted command, o_done=1 for exactly that first IDLE cycle and o_busy=0. o_result, o_status and o_err hold until the next accepted command.
  - An i_start in the o_done cycle is accepted (back-to-back commands).
- No PSEL gap is inserted between consecutive transfers other than the SETUP cycle itself.
- Latency with a slave that raises PREADY one cycle after PENABLE (3 cycles per transfer): o_done is high in cycle 16+EXE_LAT after the accepting edge.

Test Plan:
- Nominal: stub slave (PREADY one cycle late) returns 0x5A at addr 0 and 0x3 at addr 1; start with oper=0x02, argA=0x11, argB=0x22, EXE_LAT=2 → write beats 0/0x02, 1/0x11, 2/0x22; o_done at cycle 18; o_result=0x5A, o_status=0x3, o_err=0.
- Wait states: slave holds PREADY low for 4 ACCESS cycles on every transfer → address/data stable throughout ACCESS, o_done at cycle 33, results correct, o_err=0.
- Slave error: PSLVERR=1 with PREADY on transfer k=1 → no further transfers, o_done one cycle later with o_err=1, o_result=0, o_status=0.
- Timeout: PREADY tied low, TIMEOUT=15 → PSEL drops after 15 ACCESS cycles; o_done with o_err=1; the next command succeeds once PREADY is restored.
- Back-to-back/ignore: i_start held high continuously → second command accepted in the o_done cycle; i_start pulses while busy are not counted (exactly 5 transfers per command).
- Reset mid-read: assert i_PRESET during ACCESS of k=3 → o_PSEL, o_PENABLE and o_busy are 0 in the same cycle with no o_done pulse; after release a new command completes normally.

Source files
------------

// File: rtl/apb_master_exe_seq_if.sv
// Bus bundle for the APB execution-unit requester: controller command side plus APB requester side.
interface apb_master_exe_seq_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_oper;
  logic [DATA_WIDTH-1:0] i_argA;
  logic [DATA_WIDTH-1:0] i_argB;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;
  logic [3:0]            o_status;
  logic                  o_err;
  logic [ADDR_WIDTH-1:0] o_PADDR;
  logic                  o_PSEL;
  logic                  o_PENABLE;
  logic                  o_PWRITE;
  logic [DATA_WIDTH-1:0] o_PWDATA;
  logic                  i_PREADY;
  logic [DATA_WIDTH-1:0] i_PRDATA;
  logic                  i_PSLVERR;

  modport master (
    input  i_start, i_oper, i_argA, i_argB, i_PREADY, i_PRDATA, i_PSLVERR,
    output o_busy, o_done, o_result, o_status, o_err,
           o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );

  modport slave (
    output i_start, i_oper, i_argA, i_argB, i_PREADY, i_PRDATA, i_PSLVERR,
    input  o_busy, o_done, o_result, o_status, o_err,
           o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );
endinterface

// File: rtl/apb_master_exe_seq.sv
// APB requester: writes oper/argA/argB to the exe-unit slave, waits EXE_LAT cycles,
// then reads result and status back; reports completion with a one-cycle done pulse.
module apb_master_exe_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned EXE_LAT    = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic                  i_PCLK,
  input logic                  i_PRESET,
  apb_master_exe_seq_if.master bus
);
  localparam int unsigned CW       = 8;
  localparam int unsigned LAT_LAST = (EXE_LAT > 0) ? EXE_LAT - 1 : 0;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT_EXE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [CW-1:0]         tcnt_q, tcnt_d, wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] oper_q, oper_d, arga_q, arga_d, argb_q, argb_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, result_q, result_d;
  logic [3:0]            status_q, status_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  go_setup;

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_q   <= IDLE;
      k_q       <= '0;
      tcnt_q    <= '0;
      wcnt_q    <= '0;
      oper_q    <= '0;
      arga_q    <= '0;
      argb_q    <= '0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      result_q  <= '0;
      status_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      oper_q    <= oper_d;
      arga_q    <= arga_d;
      argb_q    <= argb_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      result_q  <= result_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic; every output is produced one edge ahead and registered.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tcnt_d    = tcnt_q;
    wcnt_d    = wcnt_q;
    oper_d    = oper_q;
    arga_d    = arga_q;
    argb_d    = argb_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    result_d  = result_q;
    status_d  = status_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    go_setup  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          oper_d   = bus.i_oper;
          arga_d   = bus.i_argA;
          argb_d   = bus.i_argB;
          k_d      = 3'd0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          go_setup = 1'b1;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.i_PREADY && bus.i_PSLVERR) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          result_d  = '0;
          status_d  = '0;
        end else if (bus.i_PREADY) begin
          if (k_q == 3'd3) result_d = bus.i_PRDATA;
          if (k_q == 3'd4) status_d = bus.i_PRDATA[3:0];
          if (k_q == 3'd4) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else if (k_q == 3'd2 && EXE_LAT != 0) begin
            state_d   = WAIT_EXE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            wcnt_d    = '0;
          end else begin
            k_d      = k_q + 3'd1;
            go_setup = 1'b1;
          end
        end else if (tcnt_q == CW'(TMO_LAST)) begin
          // No PREADY within the timeout window: abort exactly like a slave error.
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          result_d  = '0;
          status_d  = '0;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      WAIT_EXE: begin
        if (wcnt_q == CW'(LAT_LAST)) begin
          k_d      = 3'd3;
          go_setup = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Address/direction/data for transfer k_d, launched as a SETUP cycle.
    if (go_setup) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      tcnt_d    = '0;
      pwrite_d  = (k_d < 3'd3);
      unique case (k_d)
        3'd0:    begin paddr_d = ADDR_WIDTH'(0); pwdata_d = oper_d; end
        3'd1:    begin paddr_d = ADDR_WIDTH'(1); pwdata_d = arga_d; end
        3'd2:    begin paddr_d = ADDR_WIDTH'(2); pwdata_d = argb_d; end
        3'd3:    begin paddr_d = ADDR_WIDTH'(0); pwdata_d = '0;     end
        default: begin paddr_d = ADDR_WIDTH'(1); pwdata_d = '0;     end
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_result  = result_q;
  assign bus.o_status  = status_q;
  assign bus.o_err     = err_q;
  assign bus.o_PADDR   = paddr_q;
  assign bus.o_PSEL    = psel_q;
  assign bus.o_PENABLE = penable_q;
  assign bus.o_PWRITE  = pwrite_q;
  assign bus.o_PWDATA  = pwdata_q;
endmodule

// File: tb/tb_apb_master_exe_seq.sv
// Self-checking bench for apb_master_exe_seq: configurable APB slave stub, beat logger
// and a transaction-level model of expected beats, latency and results.
module tb_apb_master_exe_seq;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned TMO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_exe_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_master_exe_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EXE_LAT(LAT), .TIMEOUT(TMO)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESET (rst),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Slave stub configuration
  int          waits = 1;
  int          err_k = -1;
  bit          stall = 1'b0;
  logic [DW-1:0] rd0 = 8'h5A;
  logic [DW-1:0] rd1 = 8'h03;

  int acc_cyc  = 0;
  int nbeats   = 0;
  int stab_bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] s_addr;
  logic          s_wr;
  logic [DW-1:0] s_wd;
  logic [AW-1:0] log_a[$];
  bit            log_w[$];
  logic [DW-1:0] log_d[$];

  assign bus.i_PREADY  = bus.o_PSEL && bus.o_PENABLE && !stall && (acc_cyc >= waits);
  assign bus.i_PSLVERR = bus.i_PREADY && (nbeats == err_k);
  assign bus.i_PRDATA  = bus.i_PREADY ? ((bus.o_PADDR == AW'(0)) ? rd0 : rd1) : DW'(0);

  // Slave wait-state counter, beat logger and ACCESS-phase stability monitor
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cyc <= 0;
      nbeats  <= 0;
    end else begin
      if (bus.o_done) done_cnt <= done_cnt + 1;
      if (bus.o_PSEL && !bus.o_PENABLE) begin
        s_addr <= bus.o_PADDR;
        s_wr   <= bus.o_PWRITE;
        s_wd   <= bus.o_PWDATA;
      end
      if (bus.o_PSEL && bus.o_PENABLE) begin
        if (bus.o_PADDR !== s_addr || bus.o_PWRITE !== s_wr || bus.o_PWDATA !== s_wd)
          stab_bad <= stab_bad + 1;
        if (bus.i_PREADY) begin
          acc_cyc <= 0;
          nbeats  <= nbeats + 1;
          log_a.push_back(bus.o_PADDR);
          log_w.push_back(bus.o_PWRITE);
          log_d.push_back(bus.o_PWDATA);
        end else begin
          acc_cyc <= acc_cyc + 1;
        end
      end else begin
        acc_cyc <= 0;
      end
      if (!bus.o_busy) nbeats <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for o_done (bounded); optionally pulses i_start mid-command to prove it is ignored.
  task automatic wait_done(input bit pulse, output int n, output bit got, output bit busy_ok);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (pulse && n == 2) bus.i_start = 1'b1;
      if (pulse && n == 3) bus.i_start = 1'b0;
      if (bus.o_done === 1'b1) got = 1'b1;
      else if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // Transaction-level expectation for one command under the current slave configuration.
  task automatic run_cmd(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    int base, n, exp_n, exp_beats, nchk;
    bit got, busy_ok, exp_err;
    logic [DW-1:0] exp_res;
    logic [3:0]    exp_st;
    int            exp_addr[5];
    bit            exp_wr[5];
    logic [DW-1:0] exp_dat[5];
    exp_addr = '{0, 1, 2, 0, 1};
    exp_wr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_dat  = '{o, a, b, DW'(0), DW'(0)};
    if (stall) begin
      exp_beats = 0; exp_n = TMO + 2; exp_err = 1'b1;
    end else if (err_k >= 0) begin
      exp_beats = err_k + 1;
      exp_n = (err_k + 1) * (2 + waits) + ((err_k >= 3) ? LAT : 0) + 1;
      exp_err = 1'b1;
    end else begin
      exp_beats = 5; exp_n = 5 * (2 + waits) + LAT + 1; exp_err = 1'b0;
    end
    exp_res = exp_err ? DW'(0) : rd0;
    exp_st  = exp_err ? 4'h0 : rd1[3:0];

    base = log_a.size();
    bus.i_oper = o; bus.i_argA = a; bus.i_argB = b; bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0; bus.i_oper = ~o; bus.i_argA = ~a; bus.i_argB = ~b;
    wait_done(1'b1, n, got, busy_ok);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
    check({tag, "_busy_hold"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_err"}, 32'(bus.o_err), 32'(exp_err));
    check({tag, "_result"}, 32'(bus.o_result), 32'(exp_res));
    check({tag, "_status"}, 32'(bus.o_status), 32'(exp_st));
    check({tag, "_nbeats"}, 32'(log_a.size() - base), 32'(exp_beats));
    nchk = (log_a.size() - base < exp_beats) ? log_a.size() - base : exp_beats;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(log_a[base+i]), 32'(exp_addr[i]));
      check($sformatf("%s_wr%0d", tag, i), 32'(log_w[base+i]), 32'(exp_wr[i]));
      check($sformatf("%s_wdata%0d", tag, i), 32'(log_d[base+i]), 32'(exp_dat[i]));
    end
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(bus.o_done), 32'd0);
    check({tag, "_hold_result"}, 32'(bus.o_result), 32'(exp_res));
    check({tag, "_hold_err"}, 32'(bus.o_err), 32'(exp_err));
  endtask

  initial begin
    int n, n2, base, dc;
    bit got, busy_ok, hit;
    logic [DW-1:0] o2;

    bus.i_start = 1'b0; bus.i_oper = '0; bus.i_argA = '0; bus.i_argB = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(bus.o_PSEL), 32'd0);
    check("rst_penable", 32'(bus.o_PENABLE), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_result", 32'(bus.o_result), 32'd0);
    check("rst_paddr", 32'(bus.o_PADDR), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal
    waits = 1; rd0 = 8'h5A; rd1 = 8'h03;
    run_cmd("nominal", 8'h02, 8'h11, 8'h22);

    // Wait states
    waits = 4; rd0 = DW'($urandom); rd1 = DW'($urandom);
    run_cmd("waits", DW'($urandom), DW'($urandom), DW'($urandom));
    check("waits_stable", 32'(stab_bad), 32'd0);

    // Slave error on transfer 1, then on the result read
    waits = 1; err_k = 1;
    run_cmd("slverr1", DW'($urandom), DW'($urandom), DW'($urandom));
    err_k = 3;
    run_cmd("slverr3", DW'($urandom), DW'($urandom), DW'($urandom));
    err_k = -1;

    // Timeout, then recovery
    stall = 1'b1;
    run_cmd("timeout", DW'($urandom), DW'($urandom), DW'($urandom));
    stall = 1'b0;
    run_cmd("recover", DW'($urandom), DW'($urandom), DW'($urandom));

    // Randomised commands
    for (int r = 0; r < 6; r++) begin
      waits = int'($urandom_range(0, 3));
      rd0 = DW'($urandom); rd1 = DW'($urandom);
      run_cmd($sformatf("rand%0d", r), DW'($urandom), DW'($urandom), DW'($urandom));
    end
    check("rand_stable", 32'(stab_bad), 32'd0);

    // Back-to-back with i_start held high
    waits = 1; rd0 = 8'hC3; rd1 = 8'h0A;
    base = log_a.size();
    o2 = DW'($urandom);
    bus.i_oper = 8'h07; bus.i_argA = 8'h44; bus.i_argB = 8'h55; bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_oper = o2;
    wait_done(1'b0, n, got, busy_ok);
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_lat", 32'(n), 32'(5 * 3 + LAT + 1));
    check("b2b_first_result", 32'(bus.o_result), 32'h000000C3);
    wait_done(1'b0, n2, got, busy_ok);
    bus.i_start = 1'b0;
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_lat", 32'(n2), 32'(5 * 3 + LAT + 1));
    check("b2b_second_status", 32'(bus.o_status), 32'hA);
    check("b2b_beats", 32'(log_a.size() - base), 32'd10);
    if (log_a.size() - base >= 10) begin
      check("b2b_cmd1_oper", 32'(log_d[base]), 32'h07);
      check("b2b_cmd2_oper", 32'(log_d[base+5]), 32'(o2));
    end
    @(negedge clk);
    check("b2b_idle", 32'(bus.o_busy), 32'd0);

    // Reset during the ACCESS phase of the result read
    waits = 3;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (bus.o_PSEL && bus.o_PENABLE && !bus.o_PWRITE && bus.o_PADDR == AW'(0)) hit = 1'b1;
    end
    check("rstmid_reached_k3", 32'(hit), 32'd1);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check("rstmid_psel", 32'(bus.o_PSEL), 32'd0);
    check("rstmid_penable", 32'(bus.o_PENABLE), 32'd0);
    check("rstmid_busy", 32'(bus.o_busy), 32'd0);
    check("rstmid_done", 32'(bus.o_done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt - dc), 32'd0);
    waits = 1;
    run_cmd("after_rst", DW'($urandom), DW'($urandom), DW'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
